xmem_rd_ctrl: RTL
=================

Name: xmem_rd_ctrl

Overview:
- Read-side sequencer for the 2048 x 32b activation SRAM (xmem); it is the counterpart of the testbench-driven write path.
- On a start command it issues a burst of consecutive SRAM reads. It captures the 1-cycle-latency Q data into a 4-entry buffer.
- Buffered words go out on a valid/ready stream toward the L0 row loader.
- Credit-based issue: SRAM data is never dropped, including under downstream backpressure.

Parameters:
- row, 8, number of activation lanes per word
- bw, 4, bits per activation; stream/SRAM data width = bw*row (32)
- addr_bw, 11, SRAM address width (2048 words)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  addr_bw  first SRAM address of burst
- len  in  addr_bw+1  number of words, 0..2048
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse on final stream handshake
- sram_cen  out  1  SRAM chip enable, active-low, registered
- sram_wen  out  1  SRAM write enable, active-low; constant 1 (read only)
- sram_addr  out  addr_bw  SRAM address, registered
- sram_q  in  bw*row  SRAM read data, valid the cycle after sram_cen=0
- out_data  out  bw*row  buffer head word
- out_valid  out  1  buffer non-empty
- out_ready  in  1  downstream accept

Behaviour:
- Reset (reset=0, async): state IDLE, busy=0, done=0, sram_cen=1, sram_wen=1, sram_addr=0, out_valid=0, out_data=0, buffer flushed, counters 0. This applies mid-burst too; in-flight Q is discarded.
- Handshake: a word transfers when out_valid & out_ready. out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- FSM IDLE:
  - start=1 and len>0: go to READ; latch issue_addr=base_addr, issue_left=len, recv_left=len.
  - start=1 and len=0: done=1 next cycle, stay IDLE, no SRAM access.
- FSM READ:
  - Each cycle, register sram_cen=0, sram_addr=issue_addr only if issue_left>0 and (occupancy + inflight) < 4.
  - inflight counts issued reads whose data has not yet been written to the buffer (0..2).
  - On each issue: issue_addr++, wrapping 2047->0 mod 2^addr_bw; issue_left--.
  - Otherwise sram_cen=1.
  - When issue_left reaches 0, go to DRAIN.
- FSM DRAIN: sram_cen=1. Each handshake decrements recv_left. The handshake that makes recv_left 0 pulses done in the following cycle and returns to IDLE.
- Capture: the cycle after sram_cen=0, sram_q is written to the buffer tail. A simultaneous push and pop is legal at any occupancy.
- Buffer overflow is impossible by the credit rule; the bench asserts occupancy <= 4.
- Latency: start high in cycle 0 gives sram_cen=0 in cycle 1 and out_valid=1 in cycle 3.
- Throughput: with out_ready held 1, one word per cycle sustained and no gaps.
- start while busy is ignored. Bursts crossing the top address wrap silently.

Optional Feature:
- Macro XMEM_RD_PERF_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counts cycles with out_valid=1 and out_ready=0, plus READ cycles where a read was withheld by credit. Both conditions in one cycle count 1.
  - Saturates at 16'hFFFF; cleared on accepted start and on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- reset low, then start, base_addr=0, len=4, out_ready=1, SRAM preloaded with addr-valued data -> sram_cen low cycles 1-4, out_data 0,1,2,3 in cycles 3-6, done pulse cycle 7, busy low after.
- base_addr=2046, len=4 -> sram_addr sequence 2046,2047,0,1; data in same order.
- len=8, out_ready=0 until cycle 10 then 1 -> at most 4 reads issued before stall, no word lost or duplicated, 8 words in order, done once.
- out_ready toggling 1,0 every cycle, len=16 -> out_data stable during stalls, 16 ordered words. With XMEM_RD_PERF_EN, stall_cnt matches the bench stall count.
- len=0 start -> done pulse cycle 1, sram_cen stays 1; start asserted during a len=6 burst -> ignored, exactly 6 words.
- reset low in cycle 5 of a len=10 burst -> all outputs at reset values immediately; a new len=2 burst afterwards completes normally.

Source files
------------

// File: rtl/xmem_rd_ctrl.sv
// Read sequencer for the 2048x32b activation SRAM: issues credit-limited burst reads and
// streams the words through a 4-entry buffer. Define XMEM_RD_PERF_EN to add the stall_cnt port.
module xmem_rd_ctrl #(
    parameter int row     = 8,
    parameter int bw      = 4,
    parameter int addr_bw = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_bw-1:0]   base_addr,
    input  logic [addr_bw:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [addr_bw-1:0]   sram_addr,
    input  logic [bw*row-1:0]    sram_q,
    output logic [bw*row-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef XMEM_RD_PERF_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int DW    = bw * row;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state, state_n;
    logic [addr_bw-1:0] issue_addr;
    logic [addr_bw:0]   issue_left;
    logic [addr_bw:0]   recv_left;
    logic               q_vld;
    logic [DW-1:0]      fifo_mem [DEPTH];
    logic [1:0]         wr_ptr, rd_ptr;
    logic [2:0]         occ;

    logic               hs, accept, issue, finish, credit_ok;
    logic [1:0]         inflight;
    logic [addr_bw-1:0] next_rd_addr;

    assign sram_wen  = 1'b1;
    assign out_valid = (occ != 3'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign hs        = out_valid & out_ready;

    // Reads not yet landed in the buffer: one on the SRAM pins, one on the Q bus.
    assign inflight  = {1'b0, ~sram_cen} + {1'b0, q_vld};
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < 4'd4;

    // The first read goes out on the accept edge so cen drops the cycle after start.
    assign next_rd_addr = (state == IDLE) ? base_addr : issue_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len != '0) begin
                        issue   = 1'b1;
                        state_n = READ;
                    end
                end
            end
            READ: begin
                if (issue_left == '0) state_n = DRAIN;
                else if (credit_ok)   issue   = 1'b1;
            end
            DRAIN: begin
                if (hs && recv_left == {{addr_bw{1'b0}}, 1'b1}) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_addr <= '0;
            issue_left <= '0;
            recv_left  <= '0;
            sram_cen   <= 1'b1;
            sram_addr  <= '0;
            q_vld      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sram_cen <= ~issue;
            q_vld    <= ~sram_cen;
            if (issue) sram_addr <= next_rd_addr;

            if (accept) begin
                issue_addr <= base_addr + 1'b1;
                issue_left <= (len == '0) ? '0 : len - 1'b1;
                recv_left  <= len;
            end else begin
                if (issue) begin
                    issue_addr <= issue_addr + 1'b1;
                    issue_left <= issue_left - 1'b1;
                end
                if (hs) recv_left <= recv_left - 1'b1;
            end

            done <= finish | (accept & (len == '0));
            if (accept)    busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (q_vld) begin
                fifo_mem[wr_ptr] <= sram_q;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (hs) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + {2'b00, q_vld} - {2'b00, hs};
        end
    end

`ifdef XMEM_RD_PERF_EN
    logic stall_now;
    assign stall_now = (out_valid & ~out_ready) |
                       ((state == READ) & (issue_left != '0) & ~credit_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               stall_cnt <= '0;
        else if (accept)                          stall_cnt <= '0;
        else if (stall_now && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
